set_assoc_cache: RTL

Parametrised, write-back, write-allocate, set-associative data cache between the CPU load/store port and word-addressed main memory. It is the successor to the direct-mapped simple cache:
- tag, index, offset, data width and associativity (1 or 2 ways) are parameters;
- each way has dirty bits;
- victims are chosen by LRU;
- memory accesses use a request/acknowledge handshake that tolerates any memory latency.

---
 rtl/set_assoc_cache.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-back, write-allocate, LRU set-associative data cache
// Word-addressed memory side uses a req/ack handshake; every output is a registered or state-decoded signal.
module set_assoc_cache #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 3,
  parameter int WAYS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CPU_read_en,
  input  logic              CPU_write_en,
  input  logic [ADDR_W-1:0] CPU_addr,
  input  logic [DATA_W-1:0] CPU_write_din,
  output logic [DATA_W-1:0] CPU_read_dout,
  output logic              cache_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;
  state_t r_state, w_next;

  logic [DATA_W-1:0] r_data  [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]  r_tags  [WAYS][SETS];
  logic [SETS-1:0]   r_valid [WAYS];
  logic [SETS-1:0]   r_dirty [WAYS];
  logic [SETS-1:0]   r_lru;

  logic                r_op_we;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_idx;
  logic [OFFSET_W-1:0] r_off;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_victim;
  logic [OFFSET_W-1:0] r_word;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-3:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdout;

  logic                w_start;
  logic                w_hit;
  logic                w_hit_way;
  logic                w_victim;
  logic                w_vic_dirty;
  logic                w_ack;
  logic                w_last;
  logic                w_issue;
  logic [OFFSET_W-1:0] w_word_nxt;
  logic [OFFSET_W-1:0] w_issue_word;
  logic [ADDR_W-3:0]   w_issue_addr;
  logic [DATA_W-1:0]   w_issue_data;
  logic                w_unused;

  assign w_unused = ^CPU_addr[1:0];
  assign w_start  = CPU_read_en | CPU_write_en;

  // Victim: lowest-numbered invalid way, else the way the LRU bit points at
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][r_idx] && (r_tags[w][r_idx] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 1'(w);
      end
    end
    w_victim = (WAYS == 2) ? r_lru[r_idx] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][r_idx]) w_victim = 1'(w);
    end
  end

  assign w_vic_dirty  = r_valid[w_victim][r_idx] & r_dirty[w_victim][r_idx];
  assign w_ack        = r_mem_req & mem_ack;
  assign w_last       = w_ack && (r_word == OFFSET_W'(WORDS - 1));
  assign w_word_nxt   = r_word + 1'b1;
  // A burst opens with one idle setup cycle, then words are requested back to back
  assign w_issue      = ((r_state == WB) || (r_state == FILL)) && (!r_mem_req || (w_ack && !w_last));
  assign w_issue_word = r_mem_req ? w_word_nxt : r_word;
  assign w_issue_addr = {((r_state == WB) ? r_tags[r_victim][r_idx] : r_tag), r_idx, w_issue_word};
  assign w_issue_data = r_data[r_victim][r_idx][w_issue_word];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    cache_done = 1'b0;
    case (r_state)
      IDLE:    if (w_start) w_next = LOOKUP;
      LOOKUP: begin
        if (w_hit)            w_next = DONE;
        else if (w_vic_dirty) w_next = WB;
        else                  w_next = FILL;
      end
      WB:      if (w_last) w_next = FILL;
      FILL:    if (w_last) w_next = LOOKUP;
      DONE: begin
        cache_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_we     <= 1'b0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_victim    <= 1'b0;
      r_word      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdout     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op_we <= CPU_write_en;
            r_tag   <= CPU_addr[ADDR_W-1 -: TAG_W];
            r_idx   <= CPU_addr[2+OFFSET_W +: INDEX_W];
            r_off   <= CPU_addr[2 +: OFFSET_W];
            r_wdata <= CPU_write_din;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            if (!r_op_we) r_rdout <= r_data[w_hit_way][r_idx][r_off];
          end else begin
            r_victim <= w_victim;
            r_word   <= '0;
          end
        end
        default: ;
      endcase
      if (w_issue) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= (r_state == WB);
        r_mem_addr  <= w_issue_addr;
        r_mem_wdata <= (r_state == WB) ? w_issue_data : '0;
      end else if (w_last) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
      end
      if (w_ack) r_word <= w_word_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == LOOKUP) && w_hit && r_op_we)
      r_data[w_hit_way][r_idx][r_off] <= r_wdata;
    if ((r_state == FILL) && w_ack) begin
      r_data[r_victim][r_idx][r_word] <= mem_rdata;
      if (w_last) r_tags[r_victim][r_idx] <= r_tag;
    end
  end

  // The victim is invalidated as soon as it is chosen, so an interrupted refill never looks valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
      r_lru <= '0;
    end else begin
      case (r_state)
        LOOKUP: begin
          if (w_hit) begin
            r_lru[r_idx] <= ~w_hit_way;
            if (r_op_we) r_dirty[w_hit_way][r_idx] <= 1'b1;
          end else begin
            r_valid[w_victim][r_idx] <= 1'b0;
          end
        end
        WB: if (w_last) r_dirty[r_victim][r_idx] <= 1'b0;
        FILL: begin
          if (w_last) begin
            r_valid[r_victim][r_idx] <= 1'b1;
            r_dirty[r_victim][r_idx] <= r_op_we;
            r_lru[r_idx]             <= ~r_victim;
          end
        end
        default: ;
      endcase
    end
  end

  assign CPU_read_dout = r_rdout;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule
